// File: rtl/morse_pkg.sv
// Shared constants for the Morse pattern shifter: letter codes, pulse patterns and lengths.
// Patterns are sent LSB first: dot = 1, dash = 111, gap between elements = 0.
package morse_pkg;

    localparam int PAT_W_DEF = 13;
    localparam int CNT_W_DEF = 4;

    localparam logic [2:0] L_A = 3'd0;
    localparam logic [2:0] L_B = 3'd1;
    localparam logic [2:0] L_C = 3'd2;
    localparam logic [2:0] L_D = 3'd3;
    localparam logic [2:0] L_E = 3'd4;
    localparam logic [2:0] L_F = 3'd5;
    localparam logic [2:0] L_G = 3'd6;
    localparam logic [2:0] L_H = 3'd7;

    localparam logic [12:0] PAT_A = 13'h01D;
    localparam logic [12:0] PAT_B = 13'h157;
    localparam logic [12:0] PAT_C = 13'h5D7;
    localparam logic [12:0] PAT_D = 13'h057;
    localparam logic [12:0] PAT_E = 13'h001;
    localparam logic [12:0] PAT_F = 13'h175;
    localparam logic [12:0] PAT_G = 13'h177;
    localparam logic [12:0] PAT_H = 13'h055;

    localparam logic [3:0] LEN_A = 4'd5;
    localparam logic [3:0] LEN_B = 4'd9;
    localparam logic [3:0] LEN_C = 4'd11;
    localparam logic [3:0] LEN_D = 4'd7;
    localparam logic [3:0] LEN_E = 4'd1;
    localparam logic [3:0] LEN_F = 4'd9;
    localparam logic [3:0] LEN_G = 4'd9;
    localparam logic [3:0] LEN_H = 4'd7;

endpackage

// File: rtl/morse_rom.sv
// Combinational letter lookup: returns the pulse pattern and its length in bits.
module morse_rom
    import morse_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic [2:0]       letter,
    output logic [PAT_W-1:0] pattern,
    output logic [CNT_W-1:0] length
);

    always_comb begin
        pattern = '0;
        length  = '0;
        case (letter)
            L_A: begin pattern = PAT_W'(PAT_A); length = CNT_W'(LEN_A); end
            L_B: begin pattern = PAT_W'(PAT_B); length = CNT_W'(LEN_B); end
            L_C: begin pattern = PAT_W'(PAT_C); length = CNT_W'(LEN_C); end
            L_D: begin pattern = PAT_W'(PAT_D); length = CNT_W'(LEN_D); end
            L_E: begin pattern = PAT_W'(PAT_E); length = CNT_W'(LEN_E); end
            L_F: begin pattern = PAT_W'(PAT_F); length = CNT_W'(LEN_F); end
            L_G: begin pattern = PAT_W'(PAT_G); length = CNT_W'(LEN_G); end
            L_H: begin pattern = PAT_W'(PAT_H); length = CNT_W'(LEN_H); end
            default: begin pattern = '0; length = '0; end
        endcase
    end

endmodule

// File: rtl/morse_pattern_shifter.sv
// Loads a letter's pulse pattern while the blinker FSM is idle, then shifts one bit per tick.
// Zero-fill shifting keeps every bit at or above cnt cleared, so sr reaches 0 with cnt.
module morse_pattern_shifter
    import morse_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             half_sec,
    input  logic             reset,
    input  logic [2:0]       letter,
    input  logic             load,
    output logic [PAT_W-1:0] s_datain,
    output logic [CNT_W-1:0] c_datain,
    output logic             lastbit,
    output logic             busy,
    output logic             done
);

    logic [PAT_W-1:0] sr;
    logic [CNT_W-1:0] cnt;
    logic [PAT_W-1:0] rom_pattern;
    logic [CNT_W-1:0] rom_length;

    morse_rom #(.PAT_W(PAT_W), .CNT_W(CNT_W)) u_rom (
        .letter  (letter),
        .pattern (rom_pattern),
        .length  (rom_length)
    );

    always_ff @(posedge half_sec) begin
        if (reset) begin
            sr   <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (load) begin
            sr   <= rom_pattern;
            cnt  <= rom_length;
            done <= 1'b0;
        end else if (cnt != '0) begin
            sr   <= sr >> 1;
            cnt  <= cnt - 1'b1;
            done <= (cnt == CNT_W'(1));
        end else begin
            done <= 1'b0;
        end
    end

    assign s_datain = sr;
    assign c_datain = cnt;
    assign lastbit  = sr[0];
    assign busy     = (cnt != '0) && !load;

endmodule

// File: tb/tb_morse_pattern_shifter.sv
// Checks the pattern shifter against a model that builds bit queues from Morse dot/dash strings.
module tb_morse_pattern_shifter;

    logic        half_sec = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  letter = 3'd0;
    logic        load = 1'b0;
    logic [12:0] s_datain;
    logic [3:0]  c_datain;
    logic        lastbit;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    string code [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

    int q[$];
    logic done_m = 1'b0;

    morse_pattern_shifter dut (
        .half_sec (half_sec),
        .reset    (reset),
        .letter   (letter),
        .load     (load),
        .s_datain (s_datain),
        .c_datain (c_datain),
        .lastbit  (lastbit),
        .busy     (busy),
        .done     (done)
    );

    always #5 half_sec = ~half_sec;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void build(input int l);
        string s;
        s = code[l];
        q.delete();
        for (int i = 0; i < s.len(); i++) begin
            if (i > 0) q.push_back(0);
            if (s[i] == "-") begin
                q.push_back(1); q.push_back(1); q.push_back(1);
            end else begin
                q.push_back(1);
            end
        end
    endfunction

    // One clock: inputs are already stable; advance model, then compare just after the edge.
    task automatic step();
        logic [12:0] exp_s;
        @(posedge half_sec);
        if (reset) begin
            q.delete(); done_m = 1'b0;
        end else if (load) begin
            build(int'(letter)); done_m = 1'b0;
        end else if (q.size() != 0) begin
            done_m = (q.size() == 1);
            void'(q.pop_front());
        end else begin
            done_m = 1'b0;
        end
        #1;
        exp_s = '0;
        foreach (q[i]) exp_s[i] = q[i][0];
        chk("s_datain", 32'(s_datain), 32'(exp_s));
        chk("c_datain", 32'(c_datain), 32'(q.size()));
        chk("lastbit",  32'(lastbit),  32'((q.size() != 0) ? q[0] : 0));
        chk("busy",     32'(busy),     32'((q.size() != 0) && !load));
        chk("done",     32'(done),     32'(done_m));
    endtask

    task automatic load_letter(input logic [2:0] l);
        letter = l; load = 1'b1; step(); load = 1'b0;
    endtask

    initial begin
        // reset for two cycles with letter C
        reset = 1'b1; letter = 3'd2; load = 1'b0;
        step(); step();
        reset = 1'b0;

        // A, then drain and idle
        load_letter(3'd0);
        repeat (8) step();

        // E
        load_letter(3'd4);
        repeat (3) step();

        // C interrupted by a reload of D after 4 shifts
        load_letter(3'd2);
        repeat (4) step();
        letter = 3'd3; load = 1'b1; step(); load = 1'b0;
        repeat (9) step();

        // B interrupted by reset after 3 shifts
        load_letter(3'd1);
        repeat (3) step();
        reset = 1'b1; step(); reset = 1'b0;
        repeat (4) step();

        // G sent while letter toggles G/H
        load_letter(3'd6);
        for (int i = 0; i < 11; i++) begin
            letter = (i % 2 == 0) ? 3'd7 : 3'd6;
            step();
        end

        // load held high tracks letter
        load = 1'b1;
        for (int i = 0; i < 8; i++) begin
            letter = 3'(i); step();
        end
        load = 1'b0;
        repeat (12) step();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            letter = 3'($urandom_range(0, 7));
            load   = ($urandom_range(0, 9) < 2);
            reset  = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 1'b0; load = 1'b0;
        repeat (14) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
